// File: rtl/ram_arb_pkg.sv
// Shared definitions for the command-RAM arbiter: RAM opcodes, FSM states
// and the command-word width.
package ram_arb_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

    function automatic int cmd_width(input int addr_size);
        return addr_size + 2;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches from the requester after the last one granted
// and remembers the winner whenever a grant is issued.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] last_q;
    logic [PW-1:0] grant_idx;
    logic          found;

    // First pass covers indices above the pointer, second pass wraps around.
    always_comb begin
        grant     = '0;
        grant_idx = last_q;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (en && !found && req[i] && (i > int'(last_q))) begin
                grant[i]  = 1'b1;
                grant_idx = PW'(i);
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (en && !found && req[i] && (i <= int'(last_q))) begin
                grant[i]  = 1'b1;
                grant_idx = PW'(i);
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PW'(NUM_REQ - 1);
        end else if (found) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the single-port command RAM between NUM_REQ requesters, expanding
// each granted request into the RAM's two-command write or read sequence.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | idle drive on RAM, req_ready offered to one requester
//   ST_WR_ADDR | {WR_ADDR,addr} on RAM this cycle
//   ST_WR_DATA | {WR_DATA,wdata} on RAM this cycle
//   ST_RD_ADDR | {RD_ADDR,addr} on RAM this cycle
//   ST_RD_DATA | {RD_DATA,0} on RAM this cycle
//   ST_RD_WAIT | waiting for ram_tx_valid or timeout
//   ST_RESP    | read response pulse on rsp_valid
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [ADDR_SIZE-1:0]           rsp_rdata,
    output logic                           rsp_err,
    output logic [cmd_width(ADDR_SIZE)-1:0] ram_din,
    output logic                           ram_rx_valid,
    input  logic [ADDR_SIZE-1:0]           ram_dout,
    input  logic                           ram_tx_valid
);

    localparam int CW = cmd_width(ADDR_SIZE);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t               state_q;
    state_t               state_d;
    logic [NUM_REQ-1:0]   grant;
    logic                 accept;
    logic                 sel_we;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [ADDR_SIZE-1:0] sel_wdata;
    logic [NUM_REQ-1:0]   own_q;
    logic [ADDR_SIZE-1:0] wdata_q;
    logic [TW-1:0]        cnt_q;
    logic                 tmo;

    logic [CW-1:0]        ram_din_d;
    logic                 ram_rx_valid_d;
    logic [NUM_REQ-1:0]   rsp_valid_d;
    logic [ADDR_SIZE-1:0] rsp_rdata_d;
    logic                 rsp_err_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .en    (state_q == ST_IDLE),
        .grant (grant)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign tmo       = (cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_SIZE +: ADDR_SIZE];
                sel_wdata = req_wdata[i*ADDR_SIZE +: ADDR_SIZE];
            end
        end
    end

    // State register together with the registered RAM and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
            rsp_valid    <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ram_din      <= ram_din_d;
            ram_rx_valid <= ram_rx_valid_d;
            rsp_valid    <= rsp_valid_d;
            rsp_rdata    <= rsp_rdata_d;
            rsp_err      <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = sel_we ? ST_WR_ADDR : ST_RD_ADDR;
                end
            end
            ST_WR_ADDR: state_d = ST_WR_DATA;
            ST_WR_DATA: state_d = ST_IDLE;
            ST_RD_ADDR: state_d = ST_RD_DATA;
            ST_RD_DATA: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (ram_tx_valid || tmo) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Default is the idle drive: opcode 00, no strobe, so RD_DATA is never left on the bus.
    always_comb begin
        ram_din_d      = '0;
        ram_rx_valid_d = 1'b0;
        rsp_valid_d    = '0;
        rsp_rdata_d    = rsp_rdata;
        rsp_err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ram_din_d      = {(sel_we ? OP_WR_ADDR : OP_RD_ADDR), sel_addr};
                    ram_rx_valid_d = 1'b1;
                end
            end
            ST_WR_ADDR: begin
                ram_din_d      = {OP_WR_DATA, wdata_q};
                ram_rx_valid_d = 1'b1;
            end
            ST_WR_DATA: begin
                rsp_valid_d = own_q;
            end
            ST_RD_ADDR: begin
                ram_din_d      = {OP_RD_DATA, {ADDR_SIZE{1'b0}}};
                ram_rx_valid_d = 1'b1;
            end
            ST_RD_WAIT: begin
                if (ram_tx_valid) begin
                    rsp_valid_d = own_q;
                    rsp_rdata_d = ram_dout;
                end else if (tmo) begin
                    rsp_valid_d = own_q;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                own_q   <= grant;
                wdata_q <= sel_wdata;
            end
            if (state_q == ST_RD_DATA) begin
                cnt_q <= '0;
            end else if (state_q == ST_RD_WAIT) begin
                cnt_q <= cnt_q + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter: behavioural RAM plus a
// request-level reference model of memory contents, grants and responses.
module tb_ram_access_arbiter;

    localparam int N = 2;
    localparam int A = 8;
    localparam int T = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_we;
    logic [N*A-1:0]   req_addr;
    logic [N*A-1:0]   req_wdata;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     rsp_valid;
    logic [A-1:0]     rsp_rdata;
    logic             rsp_err;
    logic [A+1:0]     ram_din;
    logic             ram_rx_valid;
    logic [A-1:0]     ram_dout;
    logic             ram_tx_valid;

    int checks = 0;
    int errors = 0;

    logic [A-1:0] ref_mem [2**A];
    int           ref_last;
    bit           tb_we  [N];
    logic [A-1:0] tb_addr[N];
    logic [A-1:0] tb_data[N];
    int           tb_dly [N];
    bit           tb_sup [N];

    bit           suppress;
    int           rd_delay;
    bit           ram_clr;
    logic [A-1:0] mem [2**A];
    logic [A-1:0] ram_a;
    int           pend;

    ram_access_arbiter #(
        .NUM_REQ   (N),
        .ADDR_SIZE (A),
        .TIMEOUT   (T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid)
    );

    always #5 clk = ~clk;

    // Behavioural command RAM; read data appears rd_delay cycles after RD_DATA.
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 2**A; i++) mem[i] <= '0;
            pend         <= 0;
            ram_a        <= '0;
            ram_dout     <= '0;
            ram_tx_valid <= 1'b0;
        end else begin
            ram_tx_valid <= 1'b0;
            if (pend > 0) begin
                pend <= pend - 1;
                if (pend == 1) begin
                    ram_tx_valid <= 1'b1;
                    ram_dout     <= mem[ram_a];
                end
            end
            if (ram_rx_valid) begin
                case (ram_din[A+1:A])
                    2'b00: ram_a <= ram_din[A-1:0];
                    2'b01: mem[ram_a] <= ram_din[A-1:0];
                    2'b10: ram_a <= ram_din[A-1:0];
                    default: begin
                        if (!suppress) begin
                            if (rd_delay == 0) begin
                                ram_tx_valid <= 1'b1;
                                ram_dout     <= mem[ram_a];
                            end else begin
                                pend <= rd_delay;
                            end
                        end
                    end
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && !ram_rx_valid) chk("idle_drive", 32'(ram_din), 32'(0));
    end

    function automatic int exp_grant(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int r, input bit v, input bit we, input logic [A-1:0] a,
                           input logic [A-1:0] d, input int dl, input bit sp);
        tb_we[r]   = we;
        tb_addr[r] = a;
        tb_data[r] = d;
        tb_dly[r]  = dl;
        tb_sup[r]  = sp;
        req_valid[r]           = v;
        req_we[r]              = we;
        req_addr[r*A +: A]     = a;
        req_wdata[r*A +: A]    = d;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    // One complete transaction: grant, command sequence, response.
    task automatic serve(input bit keep);
        bit           ok;
        int           g;
        bit           we;
        logic [A-1:0] a;
        logic [A-1:0] d;
        int           dl;
        bit           sp;
        int           k;
        int           kexp;
        g = exp_grant(req_valid, ref_last);
        wait_ready(ok);
        chk("ready_seen", 32'(ok), 32'(1));
        if (!ok || g < 0) return;
        chk("grant", 32'(req_ready), 32'(1) << g);
        we = tb_we[g];
        a  = tb_addr[g];
        d  = tb_data[g];
        dl = tb_dly[g];
        sp = tb_sup[g];
        @(posedge clk);
        #1;
        ref_last = g;
        suppress = sp;
        rd_delay = dl;
        if (we) ref_mem[a] = d;
        if (keep) begin
            set_req(g, 1'b1, !we, A'($urandom), A'($urandom), $urandom_range(0, 3), 1'b0);
        end else begin
            req_valid[g] = 1'b0;
        end
        chk("rsp_clear", 32'(rsp_valid), 32'(0));
        chk("cmd0", 32'({ram_rx_valid, ram_din}), 32'({1'b1, (we ? 2'b00 : 2'b10), a}));
        @(posedge clk);
        #1;
        chk("cmd1", 32'({ram_rx_valid, ram_din}),
            we ? 32'({1'b1, 2'b01, d}) : 32'({1'b1, 2'b11, 8'h00}));
        @(posedge clk);
        #1;
        chk("cmd_idle", 32'({ram_rx_valid, ram_din}), 32'(0));
        if (we) begin
            chk("wr_rsp_valid", 32'(rsp_valid), 32'(1) << g);
            chk("wr_rsp_err", 32'(rsp_err), 32'(0));
        end else begin
            chk("rd_no_early", 32'(rsp_valid), 32'(0));
            kexp = sp ? T : dl + 1;
            k = 0;
            while (rsp_valid == '0 && k < 20) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk("rd_latency", 32'(k), 32'(kexp));
            chk("rd_rsp_valid", 32'(rsp_valid), 32'(1) << g);
            chk("rd_err", 32'(rsp_err), 32'(sp));
            chk("rd_data", 32'(rsp_rdata), sp ? 32'(0) : 32'(ref_mem[a]));
        end
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] m;
        rst       = 1'b1;
        ram_clr   = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        suppress  = 1'b0;
        rd_delay  = 0;
        ref_last  = N - 1;
        for (int i = 0; i < 2**A; i++) ref_mem[i] = '0;
        for (int r = 0; r < N; r++) set_req(r, 1'b0, 1'b0, '0, '0, 0, 1'b0);

        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_ram_din", 32'(ram_din), 32'(0));
        chk("rst_rx_valid", 32'(ram_rx_valid), 32'(0));
        chk("rst_rsp_err", 32'(rsp_err), 32'(0));
        chk("rst_rdata", 32'(rsp_rdata), 32'(0));
        rst     = 1'b0;
        ram_clr = 1'b0;
        @(negedge clk);

        // Basic write then read back through requester 0.
        set_req(0, 1'b1, 1'b1, 8'h3A, 8'h5C, 0, 1'b0);
        serve(0);
        set_req(0, 1'b1, 1'b0, 8'h3A, 8'h00, 0, 1'b0);
        serve(0);

        // Top and bottom of the address range.
        set_req(1, 1'b1, 1'b1, 8'hFF, 8'hA5, 0, 1'b0);
        serve(0);
        set_req(0, 1'b1, 1'b0, 8'hFF, 8'h00, 2, 1'b0);
        serve(0);
        set_req(1, 1'b1, 1'b1, 8'h00, 8'h11, 0, 1'b0);
        serve(0);
        set_req(1, 1'b1, 1'b0, 8'hFF, 8'h00, 3, 1'b0);
        serve(0);

        // Missing tx_valid times out, then a normal read follows.
        set_req(0, 1'b1, 1'b0, 8'h3A, 8'h00, 0, 1'b1);
        serve(0);
        set_req(1, 1'b1, 1'b0, 8'h3A, 8'h00, 1, 1'b0);
        serve(0);

        // Both requesters held valid: grants alternate.
        set_req(0, 1'b1, 1'b1, A'($urandom), A'($urandom), 0, 1'b0);
        set_req(1, 1'b1, 1'b0, A'($urandom), A'($urandom), 1, 1'b0);
        for (int i = 0; i < 8; i++) serve(1);
        req_valid = '0;

        // Random request masks, ops, RAM delays and occasional timeouts.
        for (int it = 0; it < 12; it++) begin
            m = N'($urandom_range(1, 2**N - 1));
            for (int r = 0; r < N; r++) begin
                set_req(r, m[r], 1'($urandom_range(0, 1)), A'($urandom), A'($urandom),
                        $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
            end
            serve(0);
        end
        req_valid = '0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_rx", 32'({ram_rx_valid, ram_din}), 32'(0));
            chk("idle_ready", 32'(req_ready), 32'(0));
        end

        // Reset while a read sits in RD_WAIT.
        set_req(0, 1'b1, 1'b0, 8'h3A, 8'h00, 0, 1'b1);
        begin
            bit ok;
            wait_ready(ok);
            chk("rst_case_ready", 32'(req_ready), 32'(1));
        end
        @(posedge clk);
        #1;
        ref_last     = 0;
        suppress     = 1'b1;
        req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("abort_rdata", 32'(rsp_rdata), 32'(0));
        chk("abort_err", 32'(rsp_err), 32'(0));
        chk("abort_din", 32'({ram_rx_valid, ram_din}), 32'(0));
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'(0));
        end
        rst      = 1'b0;
        ref_last = N - 1;
        suppress = 1'b0;
        repeat (T + 2) begin
            @(negedge clk);
            chk("abort_quiet", 32'(rsp_valid), 32'(0));
        end

        set_req(0, 1'b1, 1'b0, 8'h3A, 8'h00, 0, 1'b0);
        set_req(1, 1'b1, 1'b0, 8'hFF, 8'h00, 1, 1'b0);
        serve(0);
        serve(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
